// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin N-master to single-slave bus arbiter (IDLE/XFER/DONE)
// Optional slave-response timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic                          m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic                          s_ack,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic                          busy
);

    localparam int LG_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LG_W-1:0]     last_grant_q, last_grant_d;
    logic [LG_W-1:0]     winner_q, winner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                found;
    logic [LG_W-1:0]     pick;
    logic [LG_W-1:0]     cand;
    int                  idx;

    // Scan from the farthest candidate to the nearest so the nearest requester after last_grant wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            cand = LG_W'(idx);
            if (m_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d = pick;
                    we_d     = m_we[pick];
                    addr_d   = m_addr[pick*ADDR_W +: ADDR_W];
                    wdata_d  = m_wdata[pick*DATA_W +: DATA_W];
                    state_d  = XFER;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            XFER: begin
                if (s_ack) begin
                    rdata_d = s_rdata;
                    state_d = DONE;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = cnt_q + 8'd1;
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            DONE: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= LG_W'(N_MASTERS - 1);
            winner_q     <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign m_err = err_q;
`else
    assign m_err = 1'b0;
`endif

    always_comb begin
        m_ack = '0;
        if (state_q == DONE) m_ack[winner_q] = 1'b1;
    end

    assign s_req   = (state_q == XFER);
    assign busy    = (state_q != IDLE);
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign m_rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (2 masters, 17-bit addr, 8-bit data)
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  m_req = '0;
    logic [1:0]  m_we = '0;
    logic [33:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [1:0]  m_ack;
    logic        m_err;
    logic [7:0]  m_rdata;
    logic        s_req;
    logic        s_we;
    logic [16:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_ack = 1'b0;
    logic [7:0]  s_rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .N_MASTERS(2), .ADDR_W(17), .DATA_W(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_m_ack", m_ack, 2'b00);
        chk("rst_s_req", s_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_rdata", m_rdata, 8'h00);
        chk("rst_m_err", m_err, 1'b0);
        chk("rst_s_fields", {s_we, s_addr, s_wdata}, 26'h0);

        // Both masters requesting: grants alternate 0,1,0
        reset = 1'b1;
        m_addr[0 +: 17]  = 17'h00011;
        m_addr[17 +: 17] = 17'h10022;
        m_req = 2'b11;
        tick();
        chk("rr1_s_req", s_req, 1'b1);
        chk("rr1_busy", busy, 1'b1);
        chk("rr1_s_addr", s_addr, 17'h00011);
        s_ack = 1'b1; s_rdata = 8'h11;
        tick();
        chk("rr1_m_ack", m_ack, 2'b01);
        chk("rr1_m_rdata", m_rdata, 8'h11);
        chk("rr1_done_s_req", s_req, 1'b0);
        s_ack = 1'b0;
        tick();
        chk("rr1_idle_ack", m_ack, 2'b00);
        chk("rr1_idle_busy", busy, 1'b0);
        tick();
        chk("rr2_s_addr", s_addr, 17'h10022);
        s_ack = 1'b1; s_rdata = 8'h22;
        tick();
        chk("rr2_m_ack", m_ack, 2'b10);
        chk("rr2_m_rdata", m_rdata, 8'h22);
        s_ack = 1'b0;
        tick();
        tick();
        chk("rr3_s_addr", s_addr, 17'h00011);
        s_ack = 1'b1; s_rdata = 8'h33;
        tick();
        chk("rr3_m_ack", m_ack, 2'b01);
        s_ack = 1'b0; m_req = 2'b00;
        tick();

        // Master 1 read with minimum latency
        m_req = 2'b10; m_we = 2'b00;
        m_addr[17 +: 17] = 17'h10004;
        tick();
        chk("rd_s_req", s_req, 1'b1);
        chk("rd_s_we", s_we, 1'b0);
        chk("rd_s_addr", s_addr, 17'h10004);
        s_ack = 1'b1; s_rdata = 8'hA5;
        tick();
        chk("rd_m_ack", m_ack, 2'b10);
        chk("rd_m_rdata", m_rdata, 8'hA5);
        chk("rd_m_err", m_err, 1'b0);
        s_ack = 1'b0; m_req = 2'b00;
        tick();
        chk("rd_hold_rdata", m_rdata, 8'hA5);
        chk("rd_hold_ack", m_ack, 2'b00);

        // Master 0 write, s_ack delayed 5 cycles; fields stable, req drop tolerated
        m_req = 2'b01; m_we = 2'b01;
        m_addr[0 +: 17] = 17'h00010;
        m_wdata[0 +: 8] = 8'h3C;
        tick();
        for (int i = 1; i <= 5; i++) begin
            chk("wr_s_req", s_req, 1'b1);
            chk("wr_fields", {s_we, s_addr, s_wdata}, {1'b1, 17'h00010, 8'h3C});
            chk("wr_no_ack", m_ack, 2'b00);
            if (i == 2) begin
                m_addr[0 +: 17] = 17'h1FFFF;
                m_wdata[0 +: 8] = 8'h00;
                m_we = 2'b00;
            end
            if (i == 3) m_req = 2'b00;
            tick();
        end
        chk("wr_s_req6", s_req, 1'b1);
        chk("wr_fields6", {s_we, s_addr, s_wdata}, {1'b1, 17'h00010, 8'h3C});
        s_ack = 1'b1; s_rdata = 8'h5A;
        tick();
        chk("wr_m_ack", m_ack, 2'b01);
        chk("wr_m_rdata", m_rdata, 8'h5A);
        s_rdata = 8'h77;
        tick();
        chk("stray_ack_rdata", m_rdata, 8'h5A);
        chk("stray_ack_busy", busy, 1'b0);
        tick();
        chk("stray_ack_idle", {busy, m_ack, m_rdata}, {1'b0, 2'b00, 8'h5A});
        s_ack = 1'b0;

        // Reset during XFER abandons the transaction; master 0 wins next
        m_addr[0 +: 17]  = 17'h00100;
        m_addr[17 +: 17] = 17'h10200;
        m_req = 2'b11;
        tick();
        chk("rx_s_addr", s_addr, 17'h10200);
        #2 reset = 1'b0;
        #1;
        chk("rx_s_req", s_req, 1'b0);
        chk("rx_busy", busy, 1'b0);
        chk("rx_m_ack", m_ack, 2'b00);
        tick();
        chk("rx_m_ack_edge", m_ack, 2'b00);
        reset = 1'b1;
        tick();
        chk("rx2_s_addr", s_addr, 17'h00100);
        s_ack = 1'b1; s_rdata = 8'h44;
        tick();
        chk("rx2_m_ack", m_ack, 2'b01);
        s_ack = 1'b0; m_req = 2'b00;
        tick();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // No s_ack: timeout after 16 XFER cycles
        m_req = 2'b01;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_s_req", s_req, 1'b1);
            chk("to_no_ack", m_ack, 2'b00);
            tick();
        end
        chk("to_m_ack", m_ack, 2'b01);
        chk("to_m_err", m_err, 1'b1);
        chk("to_m_rdata", m_rdata, 8'hFF);
        m_req = 2'b00;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
